alu_share_arbiter: RTL

Shares one single-cycle integer ALU among up to NUM_REQ requesters (strands or helper units) that each need occasional scalar ALU operations. Round-robin arbitration picks one request per cycle, an issue register drives the ALU's op/operand inputs, and a result register returns the ALU output tagged with the requester ID over a valid/ready handshake. The block sits between the requesters and the unregistered single-stage ALU and owns all sequencing and backpressure around it.

---
 rtl/alu_share_arbiter_pkg.sv | 27 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 38 +++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared defines for the ALU sharing block: requester count default, datapath widths
// and the integer ALU opcode encodings.
package alu_share_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 4;
    localparam int unsigned OP_W            = 6;
    localparam int unsigned DATA_W          = 32;

    localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OP_W-1:0] OP_IADD  = 6'h01;
    localparam logic [OP_W-1:0] OP_ISUB  = 6'h02;
    localparam logic [OP_W-1:0] OP_IAND  = 6'h03;
    localparam logic [OP_W-1:0] OP_IOR   = 6'h04;
    localparam logic [OP_W-1:0] OP_IXOR  = 6'h05;
    localparam logic [OP_W-1:0] OP_ISLL  = 6'h06;
    localparam logic [OP_W-1:0] OP_ISRL  = 6'h07;
    localparam logic [OP_W-1:0] OP_ISRA  = 6'h08;
    localparam logic [OP_W-1:0] OP_ISLT  = 6'h09;
    localparam logic [OP_W-1:0] OP_ISLTU = 6'h0a;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] operand1;
        logic [DATA_W-1:0] operand2;
    } alu_issue_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after rr_ptr, wrapping
// modulo NUM_REQ. Grant is all-zero when enable is low.
module alu_share_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic        found;
    int unsigned sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin pick into an issue
// register driving the ALU, then a result register returned over valid/ready.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*6-1:0]    req_op,
    input  logic [NUM_REQ*32-1:0]   req_operand1,
    input  logic [NUM_REQ*32-1:0]   req_operand2,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [5:0]              alu_op,
    output logic [31:0]             alu_operand1,
    output logic [31:0]             alu_operand2,
    input  logic [31:0]             alu_result,
    output logic                    result_valid,
    output logic [ID_W-1:0]         result_id,
    output logic [31:0]             result_value,
    input  logic                    result_ready
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            i_valid_q, i_valid_d;
    logic [ID_W-1:0] i_id_q, i_id_d;
    alu_issue_t      i_q, i_d;
    logic            r_valid_q, r_valid_d;
    logic [ID_W-1:0] r_id_q, r_id_d;
    logic [31:0]     r_value_q, r_value_d;

    logic               stall;
    logic               i_can_load;
    logic               arb_en;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    alu_issue_t         sel;

    assign stall      = r_valid_q & ~result_ready;
    assign i_can_load = ~i_valid_q | ~stall;
    // Reset_n gates the grant so no acceptance is advertised while reset is held.
    assign arb_en     = i_can_load & reset_n;

    alu_share_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // One-hot operand mux from the grant vector.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.op       = req_op[6*i +: 6];
                sel.operand1 = req_operand1[32*i +: 32];
                sel.operand2 = req_operand2[32*i +: 32];
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        i_valid_d = i_valid_q;
        i_id_d    = i_id_q;
        i_d       = i_q;
        r_valid_d = r_valid_q;
        r_id_d    = r_id_q;
        r_value_d = r_value_q;

        if (i_can_load) begin
            i_valid_d = accept;
            if (accept) begin
                i_d      = sel;
                i_id_d   = grant_idx;
                rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end

        if (!stall) begin
            r_valid_d = i_valid_q;
            if (i_valid_q) begin
                r_id_d    = i_id_q;
                r_value_d = alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            i_valid_q <= 1'b0;
            i_id_q    <= '0;
            i_q       <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_value_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            i_valid_q <= i_valid_d;
            i_id_q    <= i_id_d;
            i_q       <= i_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_value_q <= r_value_d;
        end
    end

    assign alu_op       = i_q.op;
    assign alu_operand1 = i_q.operand1;
    assign alu_operand2 = i_q.operand2;
    assign result_valid = r_valid_q;
    assign result_id    = r_id_q;
    assign result_value = r_value_q;

endmodule
